// File: rtl/sprite_line_scheduler_if.sv
// Signal bundle between the line scheduler and its surroundings: CPU table writes,
// VGA line control, and the sprite line-drawer command/finish handshake.
interface sprite_line_scheduler_if #(
  parameter int IW = 4
);
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [25:0]   wr_data;
  logic          line_start;
  logic [9:0]    line_num;
  logic          draw_finish;
  logic          draw_start;
  logic [4:0]    draw_row;
  logic [9:0]    draw_col;
  logic [4:0]    draw_img;
  logic          busy;
  logic          line_done;
  logic [3:0]    hit_count;
  logic          dropped;
  logic          overrun;

  modport master (
    output wr_en, wr_addr, wr_data, line_start, line_num, draw_finish,
    input  draw_start, draw_row, draw_col, draw_img, busy, line_done,
           hit_count, dropped, overrun
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, line_start, line_num, draw_finish,
    output draw_start, draw_row, draw_col, draw_img, busy, line_done,
           hit_count, dropped, overrun
  );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: scans the attribute table one entry per cycle and
// issues one draw command per covering sprite, waiting for the drawer between commands.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_H     = 32
) (
  input logic                     clk,
  input logic                     reset,
  sprite_line_scheduler_if.slave  bus
);
  localparam int            IW       = $clog2(NUM_SPRITES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
  localparam logic [3:0]    MAX_HITS = 4'(MAX_PER_LINE);
  localparam logic [9:0]    HEIGHT   = 10'(SPRITE_H);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ARM, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;

  logic [NUM_SPRITES-1:0] en_q;
  logic [24:0]            attr_q [NUM_SPRITES];
  logic [IW-1:0]          idx;
  logic [9:0]             line_q;
  logic [3:0]             hit_cnt;
  logic                   drop_q, ovr_q;
  logic [4:0]             row_q, img_q;
  logic [9:0]             col_q;

  logic [24:0] entry;
  logic [9:0]  ent_y, diff;
  logic        hit, at_last, room, issue, advance, accept;

  // Only the enable bits need a reset; the rest of an entry is don't-care while disabled.
  always_ff @(posedge clk) begin
    if (reset) en_q <= '0;
    else if (bus.wr_en) en_q[bus.wr_addr] <= bus.wr_data[25];
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) attr_q[bus.wr_addr] <= bus.wr_data[24:0];
  end

  always_comb begin
    entry   = attr_q[idx];
    ent_y   = entry[19:10];
    diff    = line_q - ent_y;
    hit     = en_q[idx] && (line_q >= ent_y) && (diff < HEIGHT);
    at_last = (idx == LAST_IDX);
    room    = (hit_cnt < MAX_HITS);
    accept  = (state == S_IDLE) && bus.line_start;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ARM ignores draw_finish: the drawer still shows idle on the cycle it receives draw_start.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    advance  = 1'b0;
    case (state)
      S_IDLE: if (bus.line_start) state_nx = S_SCAN;
      S_SCAN: begin
        if (hit && room) begin
          issue    = 1'b1;
          state_nx = S_ARM;
        end else begin
          advance = 1'b1;
        end
      end
      S_ARM:  state_nx = S_WAIT;
      S_WAIT: if (bus.draw_finish) advance = 1'b1;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (advance) state_nx = at_last ? S_DONE : S_SCAN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      line_q  <= '0;
      hit_cnt <= '0;
      drop_q  <= 1'b0;
      ovr_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      img_q   <= '0;
    end else begin
      ovr_q <= bus.line_start && (state != S_IDLE);
      if (accept) begin
        line_q  <= bus.line_num;
        idx     <= '0;
        hit_cnt <= '0;
        drop_q  <= 1'b0;
      end
      if (issue) begin
        row_q   <= diff[4:0];
        col_q   <= entry[9:0];
        img_q   <= entry[24:20];
        hit_cnt <= hit_cnt + 4'd1;
      end
      if ((state == S_SCAN) && hit && !room) drop_q <= 1'b1;
      if (advance && !at_last) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    bus.draw_start = (state == S_ARM);
    bus.busy       = (state != S_IDLE);
    bus.line_done  = (state == S_DONE);
    bus.draw_row   = row_q;
    bus.draw_col   = col_q;
    bus.draw_img   = img_q;
    bus.hit_count  = hit_cnt;
    bus.dropped    = drop_q;
    bus.overrun    = ovr_q;
  end
endmodule
